project_ctrl: RTL and testbench

PROJECT_CTRL -- requirements
Module: project_ctrl

---
 rtl/project_ctrl.sv | 157 +++++++++++++++
 tb/tb_project_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_ctrl.sv
// Frame controller for the triangle projection pipeline: fetches each triangle, lets the
// external projection path settle, forwards unclipped results downstream, and tracks angles.
module project_ctrl #(
  parameter int WI     = 8,
  parameter int WF     = 8,
  parameter int WIIA   = 4,
  parameter int WIFA   = 8,
  parameter int AW     = 10,
  parameter int SETTLE = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_start,
  input  logic [AW-1:0]                     num_tri,
  input  logic [WIIA+WIFA-1:0]              angle_step,
  output logic [AW-1:0]                     tri_addr,
  output logic                              tri_rd,
  input  logic [9*(WI+WF)-1:0]              tri_data,
  output logic [2:0][2:0][WI+WF-1:0]        orig_triangle,
  output logic [WIIA+WIFA-1:0]              alpha,
  output logic [WIIA+WIFA-1:0]              beta,
  output logic [WIIA+WIFA-1:0]              gamma,
  input  logic [2:0][1:0][9:0]              proj_triangle,
  input  logic                              clip,
  output logic [59:0]                       out_triangle,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              frame_done,
  output logic [AW-1:0]                     drop_count,
  output logic                              overrun
);

  localparam int AN         = WIIA + WIFA;
  localparam int TWO_PI_INT = $rtoi(6.283185307179586 * (2.0 ** WIFA) + 0.5);
  localparam logic [AN:0]   TWO_PI      = TWO_PI_INT[AN:0];
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [AW-1:0] ONE_AW      = 1;
  localparam logic [AW:0]   ONE_AW1     = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ntri_q;
  logic [AW-1:0] index;
  logic [3:0]    settle_cnt;
  logic          accept;
  logic          has_tri;
  logic          last_settle;
  logic          last_tri;
  logic          advance;

  // Wrap once at 2*pi; a single subtraction is enough for any step below 2*pi.
  function automatic logic [AN-1:0] angle_add(input logic [AN-1:0] a, input logic [AN-1:0] b);
    logic [AN:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= TWO_PI) s = s - TWO_PI;
    return s[AN-1:0];
  endfunction

  always_comb begin
    accept      = (state == S_IDLE) && frame_start;
    has_tri     = (ntri_q != '0);
    last_settle = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
    last_tri    = (({1'b0, index} + ONE_AW1) == {1'b0, ntri_q});
    advance     = ((state == S_EMIT) && out_ready) || (last_settle && clip);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // An empty frame spends its FETCH cycle without a read and goes straight to DONE.
  always_comb begin
    state_nxt  = state;
    tri_rd     = 1'b0;
    tri_addr   = '0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (has_tri) begin
          tri_rd    = 1'b1;
          tri_addr  = index;
          state_nxt = S_LOAD;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_LOAD: state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (last_settle) begin
          if (!clip)        state_nxt = S_EMIT;
          else if (last_tri) state_nxt = S_DONE;
          else              state_nxt = S_FETCH;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_tri ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ntri_q        <= '0;
      index         <= '0;
      settle_cnt    <= '0;
      drop_count    <= '0;
      alpha         <= '0;
      beta          <= '0;
      gamma         <= '0;
      orig_triangle <= '0;
      out_triangle  <= '0;
      overrun       <= 1'b0;
    end else begin
      if (accept) begin
        ntri_q     <= num_tri;
        index      <= '0;
        drop_count <= '0;
        alpha      <= angle_add(alpha, angle_step);
        beta       <= angle_add(beta, angle_step);
        gamma      <= angle_add(gamma, angle_step >> 1);
      end
      if (frame_start && (state != S_IDLE)) overrun <= 1'b1;
      if (state == S_LOAD) begin
        orig_triangle <= tri_data;
        settle_cnt    <= '0;
      end
      if (state == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
      if (last_settle && !clip) out_triangle <= proj_triangle;
      if (last_settle && clip && (drop_count != '1)) drop_count <= drop_count + ONE_AW;
      if (advance) index <= index + ONE_AW;
    end
  end

endmodule

// File: tb/tb_project_ctrl.sv
// Self-checking bench for project_ctrl: hand-computed frame table, directed corner
// sequences (overrun, reset abort, EMIT stall) and randomized frames against a frame-level model.
module tb_project_ctrl;

  localparam int WI = 8, WF = 8, WIIA = 4, WIFA = 8, AW = 10, SETTLE = 4;
  localparam int CW = WI + WF;
  localparam int AN = WIIA + WIFA;
  localparam int TW = 9 * CW;

  logic                       Clk, Reset, frame_start;
  logic [AW-1:0]              num_tri;
  logic [AN-1:0]              angle_step;
  logic [AW-1:0]              tri_addr;
  logic                       tri_rd;
  logic [TW-1:0]              tri_data;
  logic [2:0][2:0][CW-1:0]    orig_triangle;
  logic [AN-1:0]              alpha, beta, gamma;
  logic [2:0][1:0][9:0]       proj_triangle;
  logic                       clip;
  logic [59:0]                out_triangle;
  logic                       out_valid, out_ready, busy, frame_done;
  logic [AW-1:0]              drop_count;
  logic                       overrun;

  project_ctrl #(.WI(WI), .WF(WF), .WIIA(WIIA), .WIFA(WIFA), .AW(AW), .SETTLE(SETTLE)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .num_tri(num_tri),
    .angle_step(angle_step), .tri_addr(tri_addr), .tri_rd(tri_rd), .tri_data(tri_data),
    .orig_triangle(orig_triangle), .alpha(alpha), .beta(beta), .gamma(gamma),
    .proj_triangle(proj_triangle), .clip(clip), .out_triangle(out_triangle),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .drop_count(drop_count), .overrun(overrun)
  );

  typedef struct {
    int          n;
    logic [11:0] step;
    logic [15:0] clips;
    int          mode;
    int          nx;
    int          drop;
    int          done;
    logic [11:0] ea, eb, eg;
  } vec_t;

  vec_t        tbl [6];
  int          nvec = 0, nerr = 0;
  int          cyc_cnt = 0, done_cnt = 0, done_cyc = 0, drop_at_done = 0;
  int          addr_q[$];
  logic [59:0] xfer_q[$];
  logic        hold_pending = 1'b0;
  logic [59:0] held = '0;
  logic [TW-1:0] mem [0:15];
  int          ref_a = 0, ref_b = 0, ref_g = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [59:0] proj_of(input logic [TW-1:0] t);
    logic [59:0] r;
    r = '0;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 2; c++)
        r[(v*2+c)*10 +: 10] = t[(v*3+c)*16+3 +: 10];
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_word();
    logic [159:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[TW-1:0];
  endfunction

  function automatic int angle_ref(input int a, input int s);
    int r;
    r = a + s;
    if (r >= 1608) r = r - 1608;
    return r & 'hFFF;
  endfunction

  function automatic int frame_cycles(input int n, input logic [15:0] clips);
    int t;
    if (n == 0) return 2;
    t = 1;
    for (int i = 0; i < n; i++) t += clips[i] ? (2 + SETTLE) : (3 + SETTLE);
    return t;
  endfunction

  // Stand-in projection datapath and triangle memory.
  assign proj_triangle = proj_of(orig_triangle);
  assign clip          = orig_triangle[0][0][0];

  initial tri_data = '0;
  always @(posedge Clk) begin
    if (tri_rd) tri_data <= mem[tri_addr[3:0]];
    else        tri_data <= rand_word();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    cyc_cnt++;
    if (Reset) begin
      hold_pending = 1'b0;
    end else begin
      if (tri_rd) addr_q.push_back(int'(tri_addr));
      if (out_valid && out_ready) xfer_q.push_back(out_triangle);
      if (frame_done) begin
        done_cnt++;
        done_cyc     = cyc_cnt;
        drop_at_done = int'(drop_count);
      end
      if (hold_pending) begin
        check("stall_valid_held", 64'(out_valid), 64'(1));
        check("stall_data_held", 64'(out_triangle), 64'(held));
      end
      hold_pending = out_valid && !out_ready;
      held         = out_triangle;
    end
  end

  task automatic fill_mem(input int n, input logic [15:0] clips);
    for (int i = 0; i < 16; i++) begin
      mem[i] = rand_word();
      if (i < n) mem[i][0] = clips[i];
    end
  endtask

  // Called at posedge+1 while idle; mode 0 = always ready, 1 = random ready, 2 = 10-cycle stall.
  task automatic run_frame(input int n, input logic [11:0] step, input int mode,
                           input logic [15:0] clips, input int exp_nx, input int exp_drop,
                           input int exp_done, input logic [11:0] ea, input logic [11:0] eb,
                           input logic [11:0] eg);
    logic [59:0] exp_q[$];
    int start, stalls;
    fill_mem(n, clips);
    for (int i = 0; i < n; i++) if (!clips[i]) exp_q.push_back(proj_of(mem[i]));
    addr_q.delete();
    xfer_q.delete();
    done_cnt    = 0;
    frame_start = 1'b1;
    num_tri     = AW'(n);
    angle_step  = step;
    out_ready   = (mode == 0);
    @(posedge Clk);
    start = cyc_cnt;
    #1;
    frame_start = 1'b0;
    check("alpha", 64'(alpha), 64'(ea));
    check("beta", 64'(beta), 64'(eb));
    check("gamma", 64'(gamma), 64'(eg));
    stalls = 0;
    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (out_valid) stalls++;
        out_ready = (stalls > 10);
      end
      @(posedge Clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    check("done_pulses", 64'(done_cnt), 64'(1));
    if (exp_done >= 0) check("done_cycle", 64'(done_cyc - start), 64'(exp_done));
    check("drop_count", 64'(drop_at_done), 64'(exp_drop));
    check("read_count", 64'(addr_q.size()), 64'(n));
    for (int i = 0; i < addr_q.size() && i < n; i++) check("read_addr", 64'(addr_q[i]), 64'(i));
    check("xfer_count", 64'(xfer_q.size()), 64'(exp_nx));
    for (int i = 0; i < xfer_q.size() && i < exp_q.size(); i++)
      check("xfer_data", 64'(xfer_q[i]), 64'(exp_q[i]));
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    int n, mode, nx, nd;
    logic [11:0] step;
    logic [15:0] clips;

    tbl[0] = '{n:3, step:12'h010, clips:16'h0000, mode:0, nx:3, drop:0, done:22, ea:12'h010, eb:12'h010, eg:12'h008};
    tbl[1] = '{n:3, step:12'h010, clips:16'h0002, mode:0, nx:2, drop:1, done:21, ea:12'h020, eb:12'h020, eg:12'h010};
    tbl[2] = '{n:0, step:12'h620, clips:16'h0000, mode:0, nx:0, drop:0, done:2,  ea:12'h640, eb:12'h640, eg:12'h320};
    tbl[3] = '{n:1, step:12'h010, clips:16'h0000, mode:2, nx:1, drop:0, done:18, ea:12'h008, eb:12'h008, eg:12'h328};
    tbl[4] = '{n:2, step:12'h001, clips:16'h0003, mode:0, nx:0, drop:2, done:13, ea:12'h009, eb:12'h009, eg:12'h328};
    tbl[5] = '{n:4, step:12'h647, clips:16'h0009, mode:0, nx:2, drop:2, done:27, ea:12'h008, eb:12'h008, eg:12'h003};

    Reset = 1'b0; frame_start = 1'b0; num_tri = '0; angle_step = '0; out_ready = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tri_rd", 64'(tri_rd), 64'(0));
    check("rst_tri_addr", 64'(tri_addr), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_alpha", 64'(alpha), 64'(0));
    check("rst_gamma", 64'(gamma), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));
    check("rst_out_tri", 64'(out_triangle), 64'(0));
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].n, tbl[i].step, tbl[i].mode, tbl[i].clips, tbl[i].nx, tbl[i].drop,
                tbl[i].done, tbl[i].ea, tbl[i].eb, tbl[i].eg);
    check("no_overrun_yet", 64'(overrun), 64'(0));

    // Empty frame with a second request arriving while busy.
    addr_q.delete(); xfer_q.delete(); done_cnt = 0;
    frame_start = 1'b1; num_tri = '0; angle_step = '0;
    @(posedge Clk);
    #1;
    check("empty_busy", 64'(busy), 64'(1));
    check("empty_no_rd", 64'(tri_rd), 64'(0));
    frame_start = 1'b1; num_tri = 10'd5;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    check("empty_done", 64'(frame_done), 64'(1));
    check("overrun_set", 64'(overrun), 64'(1));
    @(posedge Clk);
    #1;
    check("ignored_start_idle", 64'(busy), 64'(0));
    repeat (4) begin
      @(posedge Clk);
      #1;
    end
    check("empty_done_pulses", 64'(done_cnt), 64'(1));
    check("empty_reads", 64'(addr_q.size()), 64'(0));
    check("empty_xfers", 64'(xfer_q.size()), 64'(0));
    check("overrun_sticky", 64'(overrun), 64'(1));

    // Reset during SETTLE aborts the frame.
    fill_mem(3, 16'h0000);
    done_cnt = 0;
    frame_start = 1'b1; num_tri = 10'd3; angle_step = 12'h010; out_ready = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    check("pre_reset_busy", 64'(busy), 64'(1));
    Reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_tri_rd", 64'(tri_rd), 64'(0));
    check("abort_overrun", 64'(overrun), 64'(0));
    check("abort_alpha", 64'(alpha), 64'(0));
    check("abort_beta", 64'(beta), 64'(0));
    check("abort_orig", 64'(orig_triangle[2][2]), 64'(0));
    check("abort_out_tri", 64'(out_triangle), 64'(0));
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (30) begin
      @(posedge Clk);
      #1;
    end
    check("abort_no_done", 64'(done_cnt), 64'(0));

    ref_a = angle_ref(0, 'h010); ref_b = angle_ref(0, 'h010); ref_g = angle_ref(0, 'h008);
    run_frame(3, 12'h010, 0, 16'h0000, 3, 0, 22, 12'(ref_a), 12'(ref_b), 12'(ref_g));

    for (int f = 0; f < 8; f++) begin
      n     = int'($urandom_range(0, 6));
      step  = 12'($urandom_range(0, 'h647));
      clips = 16'($urandom());
      mode  = int'($urandom_range(0, 1));
      nx = 0; nd = 0;
      for (int i = 0; i < n; i++) if (clips[i]) nd++; else nx++;
      ref_a = angle_ref(ref_a, int'(step));
      ref_b = angle_ref(ref_b, int'(step));
      ref_g = angle_ref(ref_g, int'(step) / 2);
      run_frame(n, step, mode, clips, nx, nd, (mode == 0) ? frame_cycles(n, clips) : -1,
                12'(ref_a), 12'(ref_b), 12'(ref_g));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
